// File: rtl/screen_dump_tx.sv
// -----------------------------------------------------------------------------
// screen_dump_tx
// Walks a text-mode tile RAM in row-major order and streams every character
// into a UART TX FIFO, terminating each row with CR/LF. One start pulse dumps
// the whole screen; done_tick marks the end of the dump.
//
// Timing per character: READ presents the address, LATCH captures the RAM
// output one clock later, SEND waits for FIFO space and writes the byte.
// A write strobe is never issued two cycles in a row, so back-to-back byte
// states (SEND->CR, CR->LF) insert one idle cycle between writes.
// -----------------------------------------------------------------------------
module screen_dump_tx #(
   parameter int COLS       = 80,
   parameter int ROWS       = 30,
   parameter int ADDR_WIDTH = 12
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  start,
   output logic [ADDR_WIDTH-1:0] rd_addr,
   input  logic [6:0]            rd_data,
   input  logic                  tx_full,
   output logic                  wr_uart,
   output logic [7:0]            wr_data,
   output logic                  busy,
   output logic                  done_tick
);

   // Address layout is {row, col} with a fixed 7-bit column field.
   localparam int COL_W = 7;
   localparam int ROW_W = ADDR_WIDTH - COL_W;

   localparam logic [COL_W-1:0] LAST_COL = COL_W'(COLS - 1);
   localparam logic [ROW_W-1:0] LAST_ROW = ROW_W'(ROWS - 1);

   localparam logic [7:0] CHAR_SPACE = 8'h20;
   localparam logic [7:0] CHAR_CR    = 8'h0D;
   localparam logic [7:0] CHAR_LF    = 8'h0A;

   typedef enum logic [2:0] {
      IDLE,
      READ,
      LATCH,
      SEND,
      CR,
      LF,
      DONE
   } state_t;

   state_t           state;
   state_t           state_n;
   logic [ROW_W-1:0] row;
   logic [ROW_W-1:0] row_n;
   logic [COL_W-1:0] col;
   logic [COL_W-1:0] col_n;
   logic [6:0]       char_q;
   logic             last_wr;
   logic             wr_state;
   logic             wr_fire;

   // A byte state may write only when the FIFO has room and the previous
   // cycle did not already write; every state advance out of a byte state
   // is gated by this same signal, so no byte is skipped or repeated.
   assign wr_state = (state == SEND) || (state == CR) || (state == LF);
   assign wr_fire  = wr_state && !tx_full && !last_wr;

   // State register.
   // NOTE: sequential state is assigned with <= so every flop samples the
   // values from before the edge, independent of statement order.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state <= IDLE;
      end else begin
         state <= state_n;
      end
   end

   // Counters, read address, captured character and write-spacing flag.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         row     <= '0;
         col     <= '0;
         char_q  <= '0;
         rd_addr <= '0;
         last_wr <= 1'b0;
      end else begin
         row     <= row_n;
         col     <= col_n;
         last_wr <= wr_fire;
         // The address moves only on entry to READ and is then held until
         // the next character is needed.
         if ((state_n == READ) && (state != READ)) begin
            rd_addr <= {row_n, col_n};
         end
         // RAM output is valid in LATCH, one clock after the address moved.
         if (state == LATCH) begin
            char_q <= rd_data;
         end
      end
   end

   // Next-state and counter update logic.
   always_comb begin
      // NOTE: every combinational output gets a default first so no path
      // through the case statement leaves a value unassigned (no latches).
      state_n = state;
      row_n   = row;
      col_n   = col;

      unique case (state)
         IDLE: begin
            if (start) begin
               row_n   = '0;
               col_n   = '0;
               state_n = READ;
            end
         end

         READ: begin
            state_n = LATCH;
         end

         LATCH: begin
            state_n = SEND;
         end

         SEND: begin
            if (wr_fire) begin
               if (col == LAST_COL) begin
                  state_n = CR;
               end else begin
                  col_n   = col + COL_W'(1);
                  state_n = READ;
               end
            end
         end

         CR: begin
            if (wr_fire) begin
               state_n = LF;
            end
         end

         LF: begin
            if (wr_fire) begin
               if (row == LAST_ROW) begin
                  state_n = DONE;
               end else begin
                  row_n   = row + ROW_W'(1);
                  col_n   = '0;
                  state_n = READ;
               end
            end
         end

         DONE: begin
            state_n = IDLE;
         end

         default: begin
            state_n = IDLE;
         end
      endcase
   end

   // Output decode: write strobe, byte value, busy and completion pulse.
   always_comb begin
      wr_uart   = wr_fire;
      wr_data   = 8'h00;
      busy      = (state != IDLE);
      done_tick = (state == DONE);

      unique case (state)
         SEND: begin
            // Printable ASCII passes through; control codes and DEL become
            // a space so the terminal never sees stray escape bytes.
            if ((char_q >= 7'h20) && (char_q <= 7'h7E)) begin
               wr_data = {1'b0, char_q};
            end else begin
               wr_data = CHAR_SPACE;
            end
         end
         CR: begin
            wr_data = CHAR_CR;
         end
         LF: begin
            wr_data = CHAR_LF;
         end
         default: begin
            wr_data = 8'h00;
         end
      endcase
   end

endmodule

// File: tb/tb_screen_dump_tx.sv
// -----------------------------------------------------------------------------
// tb_screen_dump_tx
// Scoreboard bench: each dump pushes its expected byte stream into a queue
// built from the bench's own RAM image; a negedge monitor pops and compares on
// every wr_uart and also watches the protocol invariants on every cycle.
// -----------------------------------------------------------------------------
module tb_screen_dump_tx;

   localparam int COLS       = 80;
   localparam int ROWS       = 30;
   localparam int ADDR_WIDTH = 12;
   localparam int TOTAL      = ROWS * (COLS + 2);
   localparam int BUDGET     = 20000;

   logic                  clk;
   logic                  rst;
   logic                  start;
   logic [ADDR_WIDTH-1:0] rd_addr;
   logic [6:0]            rd_data;
   logic                  tx_full;
   logic                  wr_uart;
   logic [7:0]            wr_data;
   logic                  busy;
   logic                  done_tick;

   logic [6:0] mem [0:4095];
   logic [7:0] exp_q [$];
   logic [7:0] cap [0:TOTAL-1];

   int tests     = 0;
   int fails     = 0;
   int byte_cnt  = 0;
   int done_cnt  = 0;
   int full_mode = 0;
   int hold_cnt  = 0;
   logic prev_wr = 1'b0;

   screen_dump_tx #(
      .COLS       (COLS),
      .ROWS       (ROWS),
      .ADDR_WIDTH (ADDR_WIDTH)
   ) dut (
      .clk       (clk),
      .rst       (rst),
      .start     (start),
      .rd_addr   (rd_addr),
      .rd_data   (rd_data),
      .tx_full   (tx_full),
      .wr_uart   (wr_uart),
      .wr_data   (wr_data),
      .busy      (busy),
      .done_tick (done_tick)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Synchronous tile RAM: data appears one clock after the address.
   always @(posedge clk) rd_data <= mem[rd_addr];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %0h, expected %0h", name, act, exp);
      end
   endtask

   function automatic logic [7:0] map_char(input logic [6:0] c);
      if (c < 7'h20 || c == 7'h7F) return 8'h20;
      return {1'b0, c};
   endfunction

   task automatic push_expected();
      for (int r = 0; r < ROWS; r++) begin
         for (int c = 0; c < COLS; c++) exp_q.push_back(map_char(mem[r*128 + c]));
         exp_q.push_back(8'h0D);
         exp_q.push_back(8'h0A);
      end
   endtask

   task automatic fill(input logic [6:0] v);
      for (int a = 0; a < 4096; a++) mem[a] = v;
   endtask

   // Monitor: scoreboard compare on each write plus per-cycle invariants.
   always @(negedge clk) begin
      if (rst) begin
         check("wr_during_rst", {31'b0, wr_uart}, 0);
      end else begin
         check("wr_while_full", {31'b0, wr_uart & tx_full}, 0);
         check("wr_back_to_back", {31'b0, wr_uart & prev_wr}, 0);
         check("rd_col_range", {31'b0, rd_addr[6:0] < 7'd80}, 1);
         check("rd_row_range", {31'b0, rd_addr[11:7] < 5'd30}, 1);
         if (wr_uart) begin
            if (exp_q.size() == 0) begin
               check("sb_unexpected_byte", exp_q.size(), 1);
            end else begin
               check($sformatf("sb_byte[%0d]", byte_cnt), {24'b0, wr_data}, {24'b0, exp_q.pop_front()});
            end
            if (byte_cnt < TOTAL) cap[byte_cnt] = wr_data;
            byte_cnt++;
         end
         if (done_tick) done_cnt++;
      end
      prev_wr = wr_uart & ~rst;
   end

   // tx_full pattern: optional 50-cycle stall at byte 40, then alternating.
   initial begin
      tx_full = 1'b0;
      forever begin
         @(posedge clk);
         #1;
         if (full_mode == 1) begin
            if (hold_cnt < 50) begin
               if (byte_cnt >= 40) begin
                  tx_full = 1'b1;
                  hold_cnt++;
               end
            end else begin
               tx_full = ~tx_full;
            end
         end else begin
            tx_full = 1'b0;
         end
      end
   end

   task automatic pulse_start();
      @(posedge clk);
      #1 start = 1'b1;
      @(posedge clk);
      #1 start = 1'b0;
   endtask

   // One full dump; restart_at >= 0 re-pulses start that many cycles in.
   task automatic run_dump(input int restart_at);
      int cyc;
      push_expected();
      byte_cnt = 0;
      done_cnt = 0;
      pulse_start();
      check("busy_after_start", {31'b0, busy}, 1);
      cyc = 0;
      while (done_cnt == 0 && cyc < BUDGET) begin
         @(posedge clk);
         #1;
         cyc++;
         start = (cyc == restart_at);
      end
      start = 1'b0;
      check("dump_in_budget", {31'b0, cyc < BUDGET}, 1);
      repeat (20) @(posedge clk);
      #1;
      check("byte_count", byte_cnt, TOTAL);
      check("done_count", done_cnt, 1);
      check("queue_drained", exp_q.size(), 0);
      check("busy_after_done", {31'b0, busy}, 0);
      exp_q.delete();
   endtask

   initial begin
      int cyc;
      rst   = 1'b1;
      start = 1'b0;
      fill(7'h41);

      // Reset state.
      repeat (3) @(posedge clk);
      #1;
      check("rst_rd_addr", {20'b0, rd_addr}, 0);
      check("rst_wr_uart", {31'b0, wr_uart}, 0);
      check("rst_wr_data", {24'b0, wr_data}, 0);
      check("rst_busy", {31'b0, busy}, 0);
      check("rst_done", {31'b0, done_tick}, 0);
      rst = 1'b0;
      repeat (2) @(posedge clk);

      // All 'A', FIFO never full.
      run_dump(-1);
      check("a_byte0", {24'b0, cap[0]}, 32'h41);
      check("a_byte80", {24'b0, cap[80]}, 32'h0D);
      check("a_byte81", {24'b0, cap[81]}, 32'h0A);
      check("a_last", {24'b0, cap[TOTAL-1]}, 32'h0A);

      // Varied content with non-printables and the called-out cells.
      fill(7'h23);
      for (int r = 0; r < ROWS; r++)
         for (int c = 0; c < COLS; c++) mem[r*128 + c] = 7'((r*13 + c*7) % 128);
      mem[2*128 + 79] = 7'h5A;
      mem[29*128 + 0] = 7'h00;
      mem[0*128 + 5]  = 7'h7F;
      run_dump(-1);
      check("c_byte243", {24'b0, cap[243]}, 32'h5A);
      check("c_byte2378", {24'b0, cap[2378]}, 32'h20);
      check("c_byte5", {24'b0, cap[5]}, 32'h20);

      // Same image under FIFO back-pressure.
      hold_cnt  = 0;
      full_mode = 1;
      run_dump(-1);
      full_mode = 0;

      // Second start mid-dump must be ignored.
      run_dump(100);

      // Reset after 500 bytes aborts; next dump restarts at cell (0,0).
      push_expected();
      byte_cnt = 0;
      done_cnt = 0;
      pulse_start();
      cyc = 0;
      while (byte_cnt < 500 && cyc < BUDGET) begin
         @(posedge clk);
         cyc++;
      end
      check("abort_in_budget", {31'b0, cyc < BUDGET}, 1);
      #1 rst = 1'b1;
      #1;
      check("abort_rd_addr", {20'b0, rd_addr}, 0);
      check("abort_wr_uart", {31'b0, wr_uart}, 0);
      check("abort_wr_data", {24'b0, wr_data}, 0);
      check("abort_busy", {31'b0, busy}, 0);
      check("abort_done", {31'b0, done_tick}, 0);
      repeat (3) @(posedge clk);
      #1;
      exp_q.delete();
      check("abort_no_done", done_cnt, 0);
      rst = 1'b0;
      repeat (2) @(posedge clk);
      run_dump(-1);
      check("restart_byte0", {24'b0, cap[0]}, {24'b0, map_char(mem[0])});

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule

// File: doc/screen_dump_tx.md
SCREEN_DUMP_TX -- requirements
Module: screen_dump_tx

Interface
REQ-001 Parameter COLS, default 80, meaning characters per text row.
REQ-002 Parameter ROWS, default 30, meaning text rows per screen.
REQ-003 Parameter ADDR_WIDTH, default 12, meaning tile-RAM address width, {row[4:0], col[6:0]}.
REQ-004 Port clk, input, 1, meaning the single system clock; all state SHALL update on its rising edge.
REQ-005 Port rst, input, 1, meaning the reset, which SHALL be asynchronous and active-high.
REQ-006 Port start, input, 1, meaning a one-cycle pulse that requests a full-screen dump.
REQ-007 Port rd_addr, output, ADDR_WIDTH, meaning the tile-RAM read address, registered, {row, col}.
REQ-008 Port rd_data, input, 7, meaning the tile-RAM read data; it SHALL be taken as valid one clk after rd_addr changes.
REQ-009 Port tx_full, input, 1, meaning UART TX FIFO full.
REQ-010 Port wr_uart, output, 1, meaning a one-cycle write strobe into the UART TX FIFO.
REQ-011 Port wr_data, output, 8, meaning the byte written with wr_uart.
REQ-012 Port busy, output, 1, meaning high from the cycle after an accepted start until done_tick.
REQ-013 Port done_tick, output, 1, meaning a one-cycle pulse after the final byte of a dump is written.

Function
REQ-014 The FSM SHALL have the states IDLE, READ, LATCH, SEND, CR, LF and DONE.
REQ-015 In IDLE, start=1 SHALL load row=0 and col=0 and move to READ; start SHALL be ignored in every other state.
REQ-016 READ SHALL last exactly 1 cycle with rd_addr={row,col} held stable, then move to LATCH.
REQ-017 LATCH SHALL capture rd_data into an internal char register, then move to SEND.
REQ-018 Char mapping: wr_data={1'b0,char} when 0x20<=char<=0x7E; otherwise wr_data=0x20.
REQ-019 In SEND, wr_uart SHALL pulse only in a cycle where tx_full=0; while tx_full=1 the FSM SHALL hold with wr_uart=0.
REQ-020 After a SEND write at col<COLS-1: col SHALL increment and the FSM SHALL go to READ; at col=COLS-1 it SHALL go to CR.
REQ-021 CR SHALL write 0x0D and then go to LF; LF SHALL write 0x0A; both SHALL obey the tx_full rule of REQ-019.
REQ-022 After LF: if row<ROWS-1, row SHALL increment, col SHALL clear to 0 and the FSM SHALL go to READ; otherwise it SHALL go to DONE.
REQ-023 DONE SHALL assert done_tick for 1 cycle and then return to IDLE; busy SHALL be 0 in IDLE.
REQ-024 A complete dump SHALL write exactly ROWS*(COLS+2) bytes, 2460 at the defaults, in row-major order, with no byte skipped or duplicated under any tx_full pattern.
REQ-025 wr_uart SHALL never be high in two consecutive cycles.
REQ-026 The row and col counters SHALL never exceed ROWS-1 and COLS-1, and there SHALL be no wrap into unused addresses (col 80..127, row 30/31).
REQ-027 rd_addr SHALL change only on a transition into READ.

Reset
REQ-028 While rst=1: state=IDLE; row, col and the char register=0; rd_addr=0, wr_uart=0, wr_data=0, busy=0, done_tick=0.
REQ-029 rst asserted mid-dump SHALL abort the dump immediately, with no further wr_uart; the next start SHALL restart from address 0.

Verification
REQ-030 RAM filled with 0x41, tx_full=0, start pulse -> 2460 wr_uart pulses; bytes 80 and 81 (0-based) = 0x0D and 0x0A; last byte = 0x0A; one done_tick.
REQ-031 RAM cell (row 2, col 79)=0x5A, cell (row 29, col 0)=0x00, cell (row 0, col 5)=0x7F -> byte 243=0x5A, byte 2378=0x20, byte 5=0x20.
REQ-032 tx_full held at 1 for 50 cycles mid-row, then at 1 on alternating cycles -> wr_uart=0 while full; captured stream identical to the stream with tx_full=0.
REQ-033 start pulsed again 100 cycles into a dump -> ignored; total still 2460 bytes and a single done_tick.
REQ-034 rst pulsed after 500 bytes -> all outputs 0 the same cycle; a new start yields a full 2460-byte stream beginning at cell (0,0).
REQ-035 Assertions over every run: wr_uart never high with tx_full=1; wr_uart never high in consecutive cycles; rd_addr col<80 and row<30.
